// File: rtl/alu_issue_queue_pkg.sv
// Shared definitions for the ALU issue queue: default configuration, index-width
// derivation and the queue entry record.
package alu_issue_queue_pkg;

    localparam int IQ_DEPTH     = 4;
    localparam int IQ_RNBIT     = 2;
    localparam int IQ_PAYLOAD_W = 136;

    function automatic int idx_width(input int rnbit);
        return 5 + rnbit;
    endfunction

    function automatic int rn_depth(input int rnbit);
        return 1 << rnbit;
    endfunction

    localparam int IQ_IDX_W   = idx_width(IQ_RNBIT);
    localparam int IQ_RNDEPTH = rn_depth(IQ_RNBIT);
    localparam int IQ_OCC_W   = $clog2(IQ_DEPTH) + 1;

    typedef struct packed {
        logic                    valid;
        logic [IQ_IDX_W-1:0]     rd0;
        logic [IQ_IDX_W-1:0]     rs1;
        logic [IQ_IDX_W-1:0]     rs2;
        logic                    need1;
        logic                    need2;
        logic [IQ_PAYLOAD_W-1:0] payload;
    } iq_entry_t;

endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatch, scoreboard, execute and status signals of the ALU issue queue.
// slave = the queue itself, master = the surrounding pipeline.
interface alu_issue_queue_if
    import alu_issue_queue_pkg::*;
#(
    parameter int PAYLOAD_W = IQ_PAYLOAD_W,
    parameter int IDX_W     = IQ_IDX_W,
    parameter int RNDEPTH   = IQ_RNDEPTH,
    parameter int OCC_W     = IQ_OCC_W
);
    logic                  flush;
    logic                  dispat_vaild;
    logic                  dispat_ready;
    logic [PAYLOAD_W-1:0]  dispat_info;
    logic [IDX_W-1:0]      dispat_rd0;
    logic [IDX_W-1:0]      dispat_rs1;
    logic [IDX_W-1:0]      dispat_rs2;
    logic                  dispat_need1;
    logic                  dispat_need2;
    logic [32*RNDEPTH-1:0] wbBuf_qout;
    logic                  exe_vaild;
    logic                  exe_ready;
    logic [PAYLOAD_W-1:0]  exe_info;
    logic [IDX_W-1:0]      exe_rd0;
    logic [IDX_W-1:0]      exe_rs1;
    logic [IDX_W-1:0]      exe_rs2;
    logic [OCC_W-1:0]      occupancy;

    modport slave (
        input  flush, dispat_vaild, dispat_info, dispat_rd0, dispat_rs1, dispat_rs2,
               dispat_need1, dispat_need2, wbBuf_qout, exe_ready,
        output dispat_ready, exe_vaild, exe_info, exe_rd0, exe_rs1, exe_rs2, occupancy
    );

    modport master (
        output flush, dispat_vaild, dispat_info, dispat_rd0, dispat_rs1, dispat_rs2,
               dispat_need1, dispat_need2, wbBuf_qout, exe_ready,
        input  dispat_ready, exe_vaild, exe_info, exe_rd0, exe_rs1, exe_rs2, occupancy
    );
endinterface

// File: rtl/iq_age_select.sv
// Oldest-ready picker: older[i][j] set means slot j entered the queue before slot i.
module iq_age_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]            ready,
    input  logic [DEPTH-1:0][DEPTH-1:0] older,
    output logic [DEPTH-1:0]            grant,
    output logic                        any
);
    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = ready[i] & ~(|(ready & older[i]));
        end
    end

    assign any = |grant;
endmodule

// File: rtl/alu_issue_queue.sv
// Out-of-order issue buffer for the integer ALU: holds renamed micro-ops until their
// sources are written back, then offers the oldest ready one to execute.
module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int DEPTH     = IQ_DEPTH,
    parameter int RNBIT     = IQ_RNBIT,
    parameter int PAYLOAD_W = IQ_PAYLOAD_W
) (
    input logic              CLK,
    input logic              RST,
    alu_issue_queue_if.slave iq
);
    localparam int IDX_W = idx_width(RNBIT);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0][DEPTH-1:0] older_q;
    logic [IDX_W-1:0]            rd0_q   [DEPTH];
    logic [IDX_W-1:0]            rs1_q   [DEPTH];
    logic [IDX_W-1:0]            rs2_q   [DEPTH];
    logic                        need1_q [DEPTH];
    logic                        need2_q [DEPTH];
    logic [PAYLOAD_W-1:0]        payload_q [DEPTH];
    logic [OCC_W-1:0]            occ_q;

    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] grant;
    logic [DEPTH-1:0] keep;
    logic [DEPTH-1:0] push_sel;
    logic             any_ready;
    logic             pop;
    logic             push;
    logic             full;

    // Physical register 0 is hardwired, so it never waits on the scoreboard.
    always_comb begin
        ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = valid_q[i]
                     & (~need1_q[i] | (rs1_q[i] == '0) | iq.wbBuf_qout[rs1_q[i]])
                     & (~need2_q[i] | (rs2_q[i] == '0) | iq.wbBuf_qout[rs2_q[i]]);
        end
    end

    iq_age_select #(.DEPTH(DEPTH)) u_age_select (
        .ready (ready),
        .older (older_q),
        .grant (grant),
        .any   (any_ready)
    );

    assign iq.exe_vaild    = any_ready & ~iq.flush & ~RST;
    assign pop             = iq.exe_vaild & iq.exe_ready;
    assign full            = (occ_q == OCC_W'(DEPTH));
    assign iq.dispat_ready = ~RST & ~iq.flush & (~full | pop);
    assign push            = iq.dispat_vaild & iq.dispat_ready;
    assign keep            = valid_q & ~(pop ? grant : '0);
    assign iq.occupancy    = occ_q;

    // The slot being popped this cycle counts as free, which makes full pop+push work.
    always_comb begin
        push_sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!keep[i]) begin
                push_sel    = '0;
                push_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        iq.exe_info = '0;
        iq.exe_rd0  = '0;
        iq.exe_rs1  = '0;
        iq.exe_rs2  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i] && iq.exe_vaild) begin
                iq.exe_info = payload_q[i];
                iq.exe_rd0  = rd0_q[i];
                iq.exe_rs1  = rs1_q[i];
                iq.exe_rs2  = rs2_q[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || iq.flush) begin
            valid_q <= '0;
            older_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= keep | (push ? push_sel : '0);
            occ_q   <= occ_q + OCC_W'(push) - OCC_W'(pop);
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (push && push_sel[i])
                        older_q[i][j] <= keep[j];
                    else
                        older_q[i][j] <= older_q[i][j] & keep[i] & keep[j];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && push_sel[i]) begin
                payload_q[i] <= iq.dispat_info;
                rd0_q[i]     <= iq.dispat_rd0;
                rs1_q[i]     <= iq.dispat_rs1;
                rs2_q[i]     <= iq.dispat_rs2;
                need1_q[i]   <= iq.dispat_need1;
                need2_q[i]   <= iq.dispat_need2;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Random and directed checks of alu_issue_queue against an age-ordered list model.
module tb_alu_issue_queue;
    import alu_issue_queue_pkg::*;

    typedef logic [IQ_PAYLOAD_W-1:0] wide_t;

    logic CLK;
    logic RST;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_issue_queue_if bus ();

    alu_issue_queue dut (
        .CLK (CLK),
        .RST (RST),
        .iq  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: live entries, oldest first.
    iq_entry_t mq[$];
    bit        p_clear;
    int        p_pop;
    bit        p_push;
    iq_entry_t p_entry;

    task automatic chk(input string name, input wide_t act, input wide_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit src_ok(input logic need, input logic [IQ_IDX_W-1:0] rs);
        return !need || rs == 0 || bus.wbBuf_qout[rs];
    endfunction

    function automatic bit issuable(input iq_entry_t e);
        return src_ok(e.need1, e.rs1) && src_ok(e.need2, e.rs2);
    endfunction

    // Settle combinational outputs, compare against the model, record the edge update.
    task automatic settle();
        int sel;
        bit ev;
        bit edr;
        #1;
        sel = -1;
        for (int k = 0; k < mq.size(); k++)
            if (sel < 0 && issuable(mq[k])) sel = k;
        ev  = (sel >= 0) && !bus.flush && !RST;
        edr = !RST && !bus.flush && (mq.size() < IQ_DEPTH || (ev && bus.exe_ready));
        chk("exe_vaild", wide_t'(bus.exe_vaild), wide_t'(ev));
        chk("dispat_ready", wide_t'(bus.dispat_ready), wide_t'(edr));
        chk("occupancy", wide_t'(bus.occupancy), wide_t'(mq.size()));
        if (ev) begin
            chk("exe_info", bus.exe_info, mq[sel].payload);
            chk("exe_rd0", wide_t'(bus.exe_rd0), wide_t'(mq[sel].rd0));
            chk("exe_rs1", wide_t'(bus.exe_rs1), wide_t'(mq[sel].rs1));
            chk("exe_rs2", wide_t'(bus.exe_rs2), wide_t'(mq[sel].rs2));
        end else begin
            chk("exe_idle_data", wide_t'({bus.exe_info, bus.exe_rd0, bus.exe_rs1, bus.exe_rs2}), '0);
        end
        p_clear = RST || bus.flush;
        p_pop   = (ev && bus.exe_ready) ? sel : -1;
        p_push  = bus.dispat_vaild && edr;
        p_entry = '{valid: 1'b1, rd0: bus.dispat_rd0, rs1: bus.dispat_rs1, rs2: bus.dispat_rs2,
                    need1: bus.dispat_need1, need2: bus.dispat_need2, payload: bus.dispat_info};
    endtask

    task automatic advance();
        if (p_clear) begin
            mq.delete();
        end else begin
            if (p_pop >= 0) mq.delete(p_pop);
            if (p_push) mq.push_back(p_entry);
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle();
        bus.flush        = 1'b0;
        bus.dispat_vaild = 1'b0;
        bus.dispat_info  = '0;
        bus.dispat_rd0   = '0;
        bus.dispat_rs1   = '0;
        bus.dispat_rs2   = '0;
        bus.dispat_need1 = 1'b0;
        bus.dispat_need2 = 1'b0;
        bus.exe_ready    = 1'b0;
    endtask

    task automatic offer(input wide_t info, input int rd, input int rs1, input int rs2,
                         input bit n1, input bit n2);
        bus.dispat_vaild = 1'b1;
        bus.dispat_info  = info;
        bus.dispat_rd0   = IQ_IDX_W'(rd);
        bus.dispat_rs1   = IQ_IDX_W'(rs1);
        bus.dispat_rs2   = IQ_IDX_W'(rs2);
        bus.dispat_need1 = n1;
        bus.dispat_need2 = n2;
    endtask

    function automatic wide_t rand_payload();
        logic [159:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return w[IQ_PAYLOAD_W-1:0];
    endfunction

    initial begin
        RST = 1'b1;
        idle();
        bus.wbBuf_qout = '0;
        @(negedge CLK);

        // reset held two cycles
        settle();
        chk("t1_vaild", wide_t'(bus.exe_vaild), 0);
        chk("t1_ready", wide_t'(bus.dispat_ready), 0);
        chk("t1_occ", wide_t'(bus.occupancy), 0);
        advance();
        settle();
        advance();
        RST = 1'b0;
        settle();
        chk("t1_ready_after", wide_t'(bus.dispat_ready), 1);
        advance();

        // A waits on p9, B has no sources and overtakes it
        offer(wide_t'(136'hA0A), 3, 9, 0, 1, 0);
        settle();
        advance();
        offer(wide_t'(136'hB0B), 4, 20, 21, 0, 0);
        settle();
        chk("t2_occ1", wide_t'(bus.occupancy), 1);
        chk("t2_a_blocked", wide_t'(bus.exe_vaild), 0);
        advance();
        idle();
        bus.exe_ready = 1'b1;
        settle();
        chk("t2_b_issue", bus.exe_info, wide_t'(136'hB0B));
        chk("t2_occ2", wide_t'(bus.occupancy), 2);
        advance();
        settle();
        chk("t2_a_wait", wide_t'(bus.exe_vaild), 0);
        chk("t2_occ_after_b", wide_t'(bus.occupancy), 1);
        advance();
        bus.wbBuf_qout[9] = 1'b1;
        settle();
        chk("t2_a_same_cycle", wide_t'(bus.exe_vaild), 1);
        chk("t2_a_rs1", wide_t'(bus.exe_rs1), 9);
        advance();
        settle();
        chk("t2_occ0", wide_t'(bus.occupancy), 0);
        advance();

        // age order under back-pressure
        idle();
        bus.wbBuf_qout = '0;
        offer(wide_t'(136'hA3), 1, 0, 0, 0, 0);
        settle();
        advance();
        offer(wide_t'(136'hB3), 2, 0, 0, 0, 0);
        settle();
        chk("t3_hold1", bus.exe_info, wide_t'(136'hA3));
        advance();
        offer(wide_t'(136'hC3), 3, 0, 0, 0, 0);
        settle();
        chk("t3_hold2", bus.exe_info, wide_t'(136'hA3));
        advance();
        idle();
        settle();
        chk("t3_hold3", bus.exe_info, wide_t'(136'hA3));
        chk("t3_occ3", wide_t'(bus.occupancy), 3);
        advance();
        bus.exe_ready = 1'b1;
        settle();
        chk("t3_first", bus.exe_info, wide_t'(136'hA3));
        advance();
        settle();
        chk("t3_second", bus.exe_info, wide_t'(136'hB3));
        advance();
        settle();
        chk("t3_third", bus.exe_info, wide_t'(136'hC3));
        advance();
        settle();
        chk("t3_empty", wide_t'(bus.exe_vaild), 0);
        advance();

        // full queue, same-edge pop+push
        idle();
        for (int k = 0; k < 4; k++) begin
            offer(wide_t'(136'h400 + k), 5 + k, 10 + k, 0, 1, 0);
            settle();
            advance();
        end
        idle();
        settle();
        chk("t4_full_ready", wide_t'(bus.dispat_ready), 0);
        chk("t4_full_occ", wide_t'(bus.occupancy), 4);
        advance();
        bus.wbBuf_qout[12] = 1'b1;
        bus.exe_ready = 1'b1;
        offer(wide_t'(136'hD4), 30, 0, 0, 0, 0);
        settle();
        chk("t4_pop_rs1", wide_t'(bus.exe_rs1), 12);
        chk("t4_pop_push_ready", wide_t'(bus.dispat_ready), 1);
        advance();
        idle();
        settle();
        chk("t4_occ_stays", wide_t'(bus.occupancy), 4);
        chk("t4_new_issue", bus.exe_info, wide_t'(136'hD4));
        advance();

        // flush beats pending push and pop
        bus.flush = 1'b1;
        bus.exe_ready = 1'b1;
        offer(wide_t'(136'hE5), 31, 0, 0, 0, 0);
        settle();
        chk("t5_vaild", wide_t'(bus.exe_vaild), 0);
        chk("t5_ready", wide_t'(bus.dispat_ready), 0);
        advance();
        idle();
        settle();
        chk("t5_occ", wide_t'(bus.occupancy), 0);
        chk("t5_after", wide_t'(bus.exe_vaild), 0);
        advance();

        // rs1 = p0 is always ready
        bus.wbBuf_qout = '0;
        offer(wide_t'(136'hF6), 7, 0, 5, 1, 0);
        settle();
        advance();
        idle();
        bus.exe_ready = 1'b1;
        settle();
        chk("t6_issue", wide_t'(bus.exe_vaild), 1);
        chk("t6_info", bus.exe_info, wide_t'(136'hF6));
        advance();
        settle();
        chk("t6_occ", wide_t'(bus.occupancy), 0);
        advance();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            RST = ($urandom_range(0, 199) == 0);
            bus.flush = ($urandom_range(0, 39) == 0);
            bus.exe_ready = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0)
                bus.wbBuf_qout = {$urandom, $urandom, $urandom, $urandom}
                               & {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) != 0)
                offer(rand_payload(), $urandom_range(0, 127), $urandom_range(0, 127),
                      $urandom_range(0, 127), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            else
                bus.dispat_vaild = 1'b0;
            settle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
